div_prog: RTL

Programmable integer clock divider with 50 % duty cycle for even and odd ratios. It consumes a clock already produced by the fixed divide-by-2 stage, or any library clock, and divides it further by a run-time ratio. Ratio changes use a valid/ready handshake and take effect only at a period boundary, so `clk_out` never glitches. A one-cycle `tick` strobe in the `clk` domain marks each output period for downstream logic.

---
 rtl/div_prog_pkg.sv | 34 +++
 rtl/div_neg_ret.sv | 28 ++
 rtl/div_prog.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/div_prog_pkg.sv
// -----------------------------------------------------------------------------
// div_prog_pkg
//   Shared definitions for the programmable clock divider.
//   - div_state_t : divider FSM states (IDLE, RUN, STOP)
//   - DEF_RATIO   : division ratio loaded at reset
//   - clamp_ratio : maps the illegal ratios 0 and 1 onto 2, passes all others
// -----------------------------------------------------------------------------
package div_prog_pkg;

  // Ratio loaded into the divider when reset is asserted.
  localparam int DEF_RATIO = 2;

  // Width of the argument/result of clamp_ratio. Callers size the ratio
  // up to this width and cast the result back to their own ratio width.
  localparam int RATIO_MAX_W = 32;

  // IDLE : clk_out parked low, counter held at 0
  // RUN  : counting, en high
  // STOP : en dropped mid-period, finishing the current period
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } div_state_t;

  // A divide-by-0 or divide-by-1 request is meaningless for a 50 % clock,
  // so both become divide-by-2. Every other value is used as given.
  function automatic logic [RATIO_MAX_W-1:0] clamp_ratio(
    input logic [RATIO_MAX_W-1:0] r
  );
    return (r < 32'd2) ? 32'd2 : r;
  endfunction

endpackage

// File: rtl/div_neg_ret.sv
// -----------------------------------------------------------------------------
// div_neg_ret
//   Single flop clocked on the falling edge of clk_i. Delays d_i by half a
//   source-clock cycle; the divider uses it to stretch the high phase of
//   odd ratios by exactly half a cycle.
//
// Ports
//   clk_i : source clock (captured on negedge)
//   rst_i : asynchronous active-high reset, clears q_o
//   d_i   : data to retime
//   q_o   : d_i retimed onto the falling edge
// -----------------------------------------------------------------------------
module div_neg_ret (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o <= 1'b0;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/div_prog.sv
// -----------------------------------------------------------------------------
// div_prog
//   Programmable integer clock divider with 50 % duty cycle for both even and
//   odd ratios. The source clock is divided by a run-time ratio N. New ratios
//   are taken through a valid/ready handshake, parked in a pending register
//   and only put into force at a period boundary, so clk_out never produces a
//   short pulse. A one-cycle tick in the clk domain marks each output period.
//
// Parameters
//   W         : ratio width, legal ratios 2..2^W-1
//   DEF_RATIO : ratio in force after reset
//
// Ports
//   clk       : source clock
//   rst       : asynchronous active-high reset
//   en        : run request, level-sensitive, sampled on clk posedge
//   ratio     : requested division ratio
//   ratio_vld : ratio is valid
//   ratio_rdy : divider can accept a ratio (registered)
//   clk_out   : divided clock, 50 % duty
//   tick      : one-cycle pulse in the cycle clk_out rises
//   running   : high while the FSM is in RUN or STOP
//   dbg_state : current FSM state, for observation only
// -----------------------------------------------------------------------------
module div_prog #(
  parameter int W         = 8,
  parameter int DEF_RATIO = div_prog_pkg::DEF_RATIO
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [W-1:0]             ratio,
  input  logic                     ratio_vld,
  output logic                     ratio_rdy,
  output logic                     clk_out,
  output logic                     tick,
  output logic                     running,
  output div_prog_pkg::div_state_t dbg_state
);

  import div_prog_pkg::*;

  // Reset ratio goes through the same clamp as run-time ratios so that a
  // careless DEF_RATIO override of 0 or 1 still yields a legal divider.
  localparam logic [W-1:0] RST_RATIO = W'(clamp_ratio(32'(DEF_RATIO)));

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  div_state_t   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;        // position inside the current period
  logic [W-1:0] cur_q, cur_d;        // ratio in force
  logic [W-1:0] pend_q, pend_d;      // accepted ratio waiting for its apply point
  logic         pend_vld_q, pend_vld_d;
  logic         rdy_q, rdy_d;
  logic         q_pos_q, q_pos_d;    // posedge half of the output waveform
  logic         odd_q, odd_d;        // ratio parity aligned with q_pos_q
  logic         tick_q, tick_d;
  logic         q_neg;               // q_pos_q retimed on the falling edge

  logic         active;              // RUN or STOP
  logic         term;                // last cycle of the current period
  logic         accept;              // handshake transfer this cycle
  logic         apply;               // pending ratio goes into force this cycle

  assign active = (state_q != IDLE);
  assign term   = active && (cnt_q == (cur_q - 1'b1));

  // Handshake: a ratio is transferred on a posedge where ratio_vld and
  // ratio_rdy are both high. ratio_rdy is a register; it drops the cycle
  // after a transfer and stays low until the pending value has been applied,
  // rising again the cycle after the apply. While ratio_rdy is low,
  // ratio_vld is ignored and nothing is transferred, so a single pending
  // slot is enough and a held ratio_vld cannot overwrite the parked value.
  assign accept = ratio_vld && rdy_q;

  // While counting, a new ratio may only start on a period boundary. In
  // IDLE there is no period to protect, so the pending value goes straight in.
  assign apply  = pend_vld_q && (!active || term);

  // ---------------------------------------------------------------------------
  // FSM and period counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = term ? '0 : cnt_q + 1'b1;
        if (!en) begin
          // Dropping en on the last cycle needs no drain period.
          state_d = term ? IDLE : STOP;
        end
      end
      STOP: begin
        cnt_d = term ? '0 : cnt_q + 1'b1;
        // en coming back resumes the period already in flight; only a
        // period that completes with en still low parks the divider.
        if (en) begin
          state_d = RUN;
        end else if (term) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Ratio handshake and pending register
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    rdy_d      = rdy_q;
    cur_d      = cur_q;
    if (accept) begin
      pend_d     = W'(clamp_ratio(32'(ratio)));
      pend_vld_d = 1'b1;
      rdy_d      = 1'b0;
    end
    // accept needs rdy_q high, which implies an empty pending slot, so
    // accept and apply never coincide.
    if (apply) begin
      cur_d      = pend_q;
      pend_vld_d = 1'b0;
      rdy_d      = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output waveform
  // ---------------------------------------------------------------------------
  // q_pos is high for the first floor(N/2) counts of each period. It is
  // registered from cnt_q, so clk_out rises one cycle after the counter
  // reaches 0, together with tick. odd_q is registered from the same cur_q
  // as q_pos so the negedge extension is enabled for exactly the periods
  // it belongs to; it can only change while both q_pos and q_neg are low.
  assign q_pos_d = active && (cnt_q < (cur_q >> 1));
  assign odd_d   = cur_q[0];
  assign tick_d  = active && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_q      <= RST_RATIO;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
      q_pos_q    <= 1'b0;
      odd_q      <= RST_RATIO[0];
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      rdy_q      <= rdy_d;
      q_pos_q    <= q_pos_d;
      odd_q      <= odd_d;
      tick_q     <= tick_d;
    end
  end

  // Half-cycle delayed copy of q_pos. OR-ing it in for odd N lengthens the
  // high phase by half a cycle, giving h+0.5 high and h+0.5 low.
  div_neg_ret u_neg_ret (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (q_pos_q),
    .q_o   (q_neg)
  );

  assign clk_out   = q_pos_q | (odd_q & q_neg);
  assign tick      = tick_q;
  assign ratio_rdy = rdy_q;
  assign running   = active;
  assign dbg_state = state_q;

endmodule
